// File: rtl/fifo_sync_dxw_p1_pkg.sv
// Shared types and sizing helpers for the synchronous FIFO.
package fifo_pkg;
  localparam int OUT_STAGES = 2;

  // Occupancy of the output stage (out + skid entries), 0..2.
  typedef logic [1:0] occ_t;

  function automatic int level_bits(input int depth);
    return $clog2(depth) + 2;
  endfunction
endpackage

// File: rtl/fifo_sync_dxw_p1_if.sv
// Valid/ready word stream; master drives valid/data, slave drives ready.
interface fifo_sync_dxw_p1_if #(parameter int WIDTH = 8) ();
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fifo_sync_dxw_p1_ram.sv
// Generic true dual-port RAM, DEPTH x WIDTH, registered read (1-cycle latency) on both ports.
module ram_DxW_rwrw_p1p1 #(
  parameter  int DEPTH = 512,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic [AW-1:0]    address_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             wren_a,
  output logic [WIDTH-1:0] q_a,
  input  logic [AW-1:0]    address_b,
  input  logic [WIDTH-1:0] data_b,
  input  logic             wren_b,
  output logic [WIDTH-1:0] q_b
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wren_a) mem[address_a] <= data_a;
    if (wren_b) mem[address_b] <= data_b;
    q_a <= mem[address_a];
    q_b <= mem[address_b];
  end
endmodule

// File: rtl/fifo_sync_dxw_p1.sv
// Synchronous FIFO: RAM body plus a 2-entry output stage that hides the RAM read latency.
module fifo_sync_dxw_p1
  import fifo_pkg::*;
#(
  parameter  int DEPTH = 512,
  parameter  int WIDTH = 8,
  localparam int DB    = $clog2(DEPTH),
  localparam int LW    = level_bits(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  fifo_sync_dxw_p1_if.slave    in_s,
  fifo_sync_dxw_p1_if.master   out_s,
  output logic [LW-1:0]        level
);
  logic [DB-1:0]    wr_ptr, rd_ptr;
  logic [DB:0]      ram_cnt;
  logic             rd_pend, out_full, skid_full;
  logic [WIDTH-1:0] out_q, skid_q, q_b, unused_q_a;
  logic             push, pop, fetch;
  occ_t             occ;

  // Ready depends only on the RAM count register, never on out_ready.
  assign in_s.ready = !reset && (ram_cnt != (DB+1)'(DEPTH));
  assign push       = in_s.valid && in_s.ready;
  assign pop        = out_full && out_s.ready;
  assign occ        = occ_t'(out_full) + occ_t'(skid_full);

  // Keep (held + in-flight - leaving) within the output stage; RAM entries read
  // here were written on earlier edges, so no read-during-write case arises.
  assign fetch = (ram_cnt != '0) &&
                 ((3'(occ) + 3'(rd_pend)) < (3'(OUT_STAGES) + 3'(pop)));

  ram_DxW_rwrw_p1p1 #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_ram (
    .clock     (clock),
    .address_a (wr_ptr),
    .data_a    (in_s.data),
    .wren_a    (push),
    .q_a       (unused_q_a),
    .address_b (rd_ptr),
    .data_b    ('0),
    .wren_b    (1'b0),
    .q_b       (q_b)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      rd_pend   <= 1'b0;
      out_full  <= 1'b0;
      skid_full <= 1'b0;
      out_q     <= '0;
      skid_q    <= '0;
      level     <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + DB'(1);
      if (fetch) rd_ptr <= rd_ptr + DB'(1);
      rd_pend <= fetch;
      ram_cnt <= ram_cnt + (DB+1)'(push) - (DB+1)'(fetch);
      // Total held = ram_cnt + rd_pend + occ, tracked incrementally.
      level   <= level + LW'(push) - LW'(pop);

      if (rd_pend) begin
        if (!out_full || (pop && !skid_full)) begin
          out_q    <= q_b;
          out_full <= 1'b1;
        end else if (pop) begin
          out_q  <= skid_q;
          skid_q <= q_b;
        end else begin
          skid_q    <= q_b;
          skid_full <= 1'b1;
        end
      end else if (pop) begin
        if (skid_full) begin
          out_q     <= skid_q;
          skid_full <= 1'b0;
        end else begin
          out_full <= 1'b0;
        end
      end
    end
  end

  assign out_s.valid = out_full;
  assign out_s.data  = out_q;
endmodule

// File: tb/tb_fifo_sync_dxw_p1.sv
// Scoreboard bench for fifo_sync_dxw_p1 (DEPTH=4 so full and wrap cases are reached often).
module tb_fifo_sync_dxw_p1;
  localparam int DEPTH = 4;
  localparam int WIDTH = 8;

  logic       clock, reset;
  logic [3:0] level;

  fifo_sync_dxw_p1_if #(.WIDTH(WIDTH)) in_s ();
  fifo_sync_dxw_p1_if #(.WIDTH(WIDTH)) out_s ();

  fifo_sync_dxw_p1 #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .in_s  (in_s),
    .out_s (out_s),
    .level (level)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of accepted words and their count.
  logic [7:0] q[$];
  int         cnt = 0;
  logic       hold = 1'b0;
  logic [7:0] hold_d = '0;

  always @(negedge clock) begin
    if (reset) begin
      chk("rst_in_ready", 32'(in_s.ready), 0);
      q.delete();
      cnt  = 0;
      hold = 1'b0;
    end else begin
      chk("level", 32'(level), cnt);
      if (cnt == 0)         chk("empty_out_valid", 32'(out_s.valid), 0);
      if (cnt < DEPTH)      chk("in_ready_room", 32'(in_s.ready), 1);
      if (cnt == DEPTH + 2) chk("in_ready_full", 32'(in_s.ready), 0);
      if (hold) begin
        chk("hold_valid", 32'(out_s.valid), 1);
        chk("hold_data", 32'(out_s.data), 32'(hold_d));
      end
      if (out_s.valid && out_s.ready) begin
        if (q.size() == 0) chk("sb_underflow", 32'(q.size()), 1);
        else chk("sb_data", 32'(out_s.data), 32'(q.pop_front()));
        cnt--;
      end
      if (in_s.valid && in_s.ready) begin
        q.push_back(in_s.data);
        cnt++;
      end
      hold   = out_s.valid && !out_s.ready;
      hold_d = out_s.data;
    end
  end

  // One clock of stimulus; returns what was seen at the sample point before the edge.
  task automatic cyc(input logic iv, input logic [7:0] d, input logic ordy,
                     output logic acc, output logic ov, output logic [7:0] od);
    in_s.valid = iv;
    in_s.data  = d;
    out_s.ready = ordy;
    @(negedge clock);
    acc = iv && in_s.ready;
    ov  = out_s.valid;
    od  = out_s.data;
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    logic a, v;
    logic [7:0] d;
    while (cnt != 0 && n < 200) begin
      cyc(1'b0, 8'h00, 1'b1, a, v, d);
      n++;
    end
    cyc(1'b0, 8'h00, 1'b0, a, v, d);
    chk("drain_empty", cnt, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a, v;
    logic [7:0] d;
    int pushed, n;

    reset = 1'b1;
    in_s.valid = 1'b0; in_s.data = '0; out_s.ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_out_valid", 32'(out_s.valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_out_data", 32'(out_s.data), 0);
    chk("rst_in_ready_after", 32'(in_s.ready), 1);
    @(posedge clock); #1;

    // 1: five words, out_valid rises two clocks after first push edge
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 8'(i + 1), 1'b0, a, v, d);
      chk("t1_acc", 32'(a), 1);
      if (i == 1 || i == 2) chk("t1_latency_low", 32'(v), 0);
      if (i == 3)           chk("t1_latency_high", 32'(v), 1);
    end
    in_s.valid = 1'b0;
    @(negedge clock);
    chk("t1_level", 32'(level), 5);
    @(posedge clock); #1;
    drain();

    // 2: overfill a DEPTH=4 FIFO; only DEPTH+2 words fit
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'hA0 + 8'(i), 1'b0, a, v, d);
      chk("t2_acc", 32'(a), (i < 6) ? 1 : 0);
    end
    in_s.valid = 1'b0;
    @(negedge clock);
    chk("t2_level", 32'(level), 6);
    chk("t2_in_ready", 32'(in_s.ready), 0);
    @(posedge clock); #1;
    drain();
    @(negedge clock);
    chk("t2_level_drained", 32'(level), 0);
    @(posedge clock); #1;

    // 6: push and pop offered together at full
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 8'h60 + 8'(i), 1'b0, a, v, d);
      chk("t6_fill_acc", 32'(a), 1);
    end
    cyc(1'b1, 8'h77, 1'b1, a, v, d);
    chk("t6_push_blocked", 32'(a), 0);
    chk("t6_pop_valid", 32'(v), 1);
    in_s.valid = 1'b0; out_s.ready = 1'b0;
    @(negedge clock);
    chk("t6_in_ready_next", 32'(in_s.ready), 1);
    chk("t6_level", 32'(level), 5);
    @(posedge clock); #1;
    drain();

    // 3: continuous streaming, wraps pointers three times
    for (int i = 0; i < 3 * DEPTH + 3; i++) begin
      cyc(i < 3 * DEPTH, 8'(i), 1'b1, a, v, d);
      if (i < 3 * DEPTH) chk("t3_in_ready", 32'(a), 1);
      chk("t3_out_valid", 32'(v), (i >= 3) ? 1 : 0);
    end
    drain();

    // 5: reset mid-stream discards contents
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h11 * 8'(i + 1), 1'b0, a, v, d);
    reset = 1'b1; in_s.valid = 1'b1; in_s.data = 8'h99; out_s.ready = 1'b1;
    @(negedge clock);
    chk("t5_in_ready_rst", 32'(in_s.ready), 0);
    @(posedge clock); #1;
    reset = 1'b0; in_s.valid = 1'b0; out_s.ready = 1'b0;
    @(negedge clock);
    chk("t5_out_valid", 32'(out_s.valid), 0);
    chk("t5_level", 32'(level), 0);
    @(posedge clock); #1;
    cyc(1'b1, 8'h44, 1'b0, a, v, d);
    n = 0; v = 1'b0;
    while (!v && n < 8) begin
      cyc(1'b0, 8'h00, 1'b0, a, v, d);
      n++;
    end
    chk("t5_first_valid", 32'(v), 1);
    chk("t5_first_data", 32'(d), 32'h44);
    drain();

    // 4: random traffic
    pushed = 0; n = 0;
    while (pushed < 10000 && n < 60000) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), a, v, d);
      if (a) pushed++;
      n++;
    end
    chk("t4_pushed", pushed, 10000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fifo_sync_dxw_p1.md
Name: fifo_sync_DxW_p1

Overview:
Synchronous single-clock FIFO with valid/ready streams on both sides. It is the initiator that drives the generic dual-port RAM primitive.
- Port A is write-only and is the producer side.
- Port B is read-only and is the consumer side.
- The RAM's 1-cycle read latency is hidden by a 2-entry output stage, giving sustained 1 word/clock throughput.
- Used as the standard elastic buffer between pipeline stages (e.g. instruction/data stream buffering).

Parameters:
DEPTH, 512, RAM entries; power of 2, >= 4; DEPTH_BITS = $clog2(DEPTH)
WIDTH, 8, data word width in bits

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  producer has a word
in_ready  out  1  FIFO can accept; transfer when in_valid && in_ready at rising edge
in_data  in  WIDTH  producer word
out_valid  out  1  head word available
out_ready  in  1  consumer takes head; transfer when out_valid && out_ready at rising edge
out_data  out  WIDTH  head word; stable while out_valid && !out_ready
level  out  DEPTH_BITS+2  total words held (RAM + in-flight read + output stage)

Behaviour:
Interface:
- One clock (clock); reset is synchronous and active-high (reset).

Reset state (clock edge with reset=1):
- wr_ptr=0, rd_ptr=0, ram_cnt=0, rd_pend=0.
- out and skid entries empty; out_data=0; level=0; out_valid=0.
- in_ready=0 while reset is high; in_ready=1 from the first cycle after reset deasserts.
- Reset mid-operation discards all contents; no output transfer occurs on that edge.

Capacity:
- DEPTH+2 words: DEPTH in RAM, 2 in the output stage.
- in_ready = (ram_cnt != DEPTH), decoded directly from registers.
- No combinational path from out_ready to in_ready.

Push:
- On accepted input: RAM port A wren_a=1, address_a=wr_ptr, data_a=in_data.
- wr_ptr increments modulo DEPTH (natural wrap).

Fetch (combinational, issued on port B):
- fetch = ram_cnt!=0 && (occ + rd_pend - pop) < 2, where occ = output entries held (0..2) and pop = out_valid && out_ready.
- address_b=rd_ptr, wren_b=0 always. rd_ptr increments mod DEPTH on fetch; rd_pend <= fetch.
- ram_cnt next = ram_cnt + push - fetch.
- Fetch only reads entries written on earlier edges. The same-address read/write hazard is therefore impossible and must not rely on the RAM's read-during-write behaviour.

Capture (rd_pend=1, q_b valid this cycle):
- Output empty, or pop with skid empty -> q_b goes to out.
- Pop with skid full -> out <= skid, skid <= q_b.
- Otherwise -> q_b goes to skid.
- Pop without capture: out <= skid if skid full, else out becomes empty.

Output:
- out_valid = out entry full (registered).
- Ordering is strictly FIFO.

Latency:
- Word accepted at edge E0 into an empty FIFO gives out_valid=1 after edge E2 (2 clocks).
- Steady state with out_ready=1: one word per clock in and out.

Level:
- level = ram_cnt + rd_pend + occ, registered, updated every edge.

Boundaries:
- Full: in_ready=0; in_valid ignored, with no pointer change.
- Empty: out_valid=0; out_ready ignored.
- Simultaneous push and pop at full: push still blocked that cycle; in_ready rises next cycle.
- Pointer wrap: occurs at DEPTH-1 -> 0 and must be transparent.

Decomposition:
- Shared package fifo_pkg:
  - function for the level width (DEPTH_BITS+2);
  - constant OUT_STAGES=2;
  - typedef for the 2-entry output-stage occupancy.
- One sub-module instance: ram_DxW_rwrw_p1p1 (DEPTH, WIDTH), port A = write, port B = read.
- Output stage kept inline, no further sub-modules.

Test Plan:
1. Reset, then push 0x01..0x05 with out_ready=0 -> level=5, then out_ready=1 yields 0x01..0x05 in order, out_valid first high 2 clocks after first push edge.
2. DEPTH=4: push 8 words 0xA0..0xA7, out_ready=0.
   - Expected: in_ready drops after 6 accepted, level=6, 0xA6/0xA7 not accepted.
   - Then draining yields 0xA0..0xA5 and level returns to 0.
3. Continuous in_valid=1, out_ready=1, 3*DEPTH incrementing words -> after 2-clock fill, one output per clock, no gaps, values match, pointers wrap cleanly.
4. Random in_valid/out_ready (50%), 10000 words -> scoreboard exact match.
   - out_data stable whenever out_valid && !out_ready.
   - level always equals pushed-popped.
5. Push 0x11,0x22,0x33; assert reset one cycle mid-stream -> out_valid=0, level=0, in_ready=0 during reset; then push 0x44 -> first output 0x44.
6. FIFO full (DEPTH=4, level=6), assert in_valid and out_ready same cycle -> pop occurs, push rejected, in_ready=1 next cycle, level=5.
